fir_uart_sequencer: RTL and testbench
=====================================

Name: fir_uart_sequencer

Overview:
Sequences the FIR_sync engine from the UART byte streams. It assembles received UART bytes into 16-bit signed samples and issues each sample to the FIR as a single-cycle input_valid strobe. It then waits, with a timeout, for the FIR result and serializes the sign-extended result onto the UART transmitter, least-significant byte first. It sits between the UART RX/TX cores and FIR_sync in the top level.

Parameters:
WIDTH, 16, FIR sample width; must be 16 (two bytes per sample)
OUT_WIDTH, 37, FIR result width (2*WIDTH + LOG2_CEIL(64) - 1)
OUT_BYTES, 5, bytes transmitted per result; OUT_BYTES*8 >= OUT_WIDTH
TIMEOUT, 255, maximum cycles to wait for fir_output_valid after issue

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
fir_input  out  16  sample to FIR_sync.FIR_input
fir_input_valid  out  1  one-cycle issue strobe to FIR_sync.input_valid
fir_output  in  37  FIR_sync.FIR_output
fir_output_valid  in  1  FIR_sync.output_valid
tx_data  out  8  byte to UART TX
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  UART TX busy
busy  out  1  high in any state except IDLE
overrun  out  1  sticky: a received byte was dropped
timeout_err  out  1  sticky: the FIR result did not arrive in time
err_clr  in  1  clears overrun and timeout_err

Behaviour:
- Reset (rst=0, async): state=IDLE. fir_input=0, fir_input_valid=0, tx_data=0, tx_start=0, busy=0, overrun=0, timeout_err=0, timeout counter=0, byte index=0, result register=0.
- All outputs are registered.
- IDLE:
  - On rx_valid, latch rx_data into sample[7:0] and go to HALF.
- HALF:
  - On rx_valid, latch rx_data into sample[15:8] and go to ISSUE.
  - There is no inter-byte timeout.
- ISSUE:
  - fir_input_valid=1 for exactly one cycle, with fir_input equal to the assembled sample.
  - The strobe occurs the cycle after the high byte is accepted.
  - fir_input holds its value until the next issue.
  - Clear the timeout counter and go to WAIT_RES.
- WAIT_RES:
  - Increment the counter each cycle.
  - On fir_output_valid, capture {sign-extend fir_output to OUT_BYTES*8}, set byte index=0 and go to SEND.
  - If the counter reaches TIMEOUT without fir_output_valid, set timeout_err and go to IDLE. No bytes are sent.
  - If fir_output_valid arrives in the same cycle the counter reaches TIMEOUT, the result wins.
- SEND:
  - Wait for tx_busy=0.
  - Then drive tx_data = result byte[index] and pulse tx_start=1 for one cycle.
  - Go to TX_ACK.
- TX_ACK:
  - Wait for tx_busy=1, then go to TX_WAIT.
- TX_WAIT:
  - Wait for tx_busy=0.
  - If index==OUT_BYTES-1, go to IDLE; otherwise increment index and go to SEND.
- Byte order: LSB first. Byte k is result[8k+7:8k].
- rx_valid in ISSUE, WAIT_RES, SEND, TX_ACK or TX_WAIT: the byte is dropped and overrun is set. The state machine is unaffected.
- fir_output_valid outside WAIT_RES is ignored.
- Sticky flags: err_clr=1 clears both flags next cycle. A new error event in the same cycle as err_clr wins (the flag stays 1).
- Reset mid-operation discards any partial sample and pending result; no partial transmit resumes.
- Throughput: one sample in flight at a time. The next sample may start once the state returns to IDLE.

Test Plan:
- Basic path: rx 0x34 then 0x12 → fir_input=16'h1234 with one cycle of fir_input_valid, one cycle after the second byte. Return fir_output=37'd5 after 195 cycles → tx bytes 05 00 00 00 00, five tx_start pulses, then busy=0.
- Negative result: fir_output=-2 (37'h1F_FFFF_FFFE) → tx bytes FE FF FF FF FF, showing sign extension of bits 39:37.
- Timeout: issue a sample and never assert fir_output_valid → after 255 cycles timeout_err=1, state IDLE, no tx_start. A late fir_output_valid is ignored. err_clr → timeout_err=0.
- Overrun: rx_valid with byte 0xAA during WAIT_RES → overrun=1, transmitted result unchanged. Assert err_clr and a dropped byte in the same cycle → overrun stays 1.
- TX backpressure: hold tx_busy=1 for 100 cycles per byte → exactly one tx_start per byte, never while tx_busy=1, byte order preserved.
- Reset mid-transmit: assert rst low after byte 2 of 5 → all outputs are 0 immediately. After release, rx 0x01, 0x00 → fir_input=16'h0001.

Source files
------------

// File: rtl/fir_uart_sequencer.sv
// Two RX bytes (LSB first) form a sample issued to the FIR one cycle after the high byte; the result is sent back LSB first.
// Backpressure: waits on tx_busy per byte, bytes arriving while a sample is in flight are dropped and flagged.
module fir_uart_sequencer #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 37,
  parameter int OUT_BYTES = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [WIDTH-1:0]     fir_input,
  output logic                 fir_input_valid,
  input  logic [OUT_WIDTH-1:0] fir_output,
  input  logic                 fir_output_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  input  logic                 err_clr
);
  localparam int RES_W = OUT_BYTES * 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HALF     = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] TX_ACK   = 3'd5;
  localparam logic [2:0] TX_WAIT  = 3'd6;

  logic [2:0]       state, state_n;
  logic [7:0]       sample_lo;
  logic [CNT_W-1:0] tmo_cnt;
  logic [IDX_W-1:0] byte_idx;
  logic [RES_W-1:0] result;
  logic             res_hit, tmo_hit, last_byte, drop;

  // A result arriving on the final wait cycle takes priority over the timeout.
  assign res_hit   = (state == WAIT_RES) && fir_output_valid;
  assign tmo_hit   = (state == WAIT_RES) && !fir_output_valid &&
                     (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign last_byte = (byte_idx == IDX_W'(OUT_BYTES - 1));
  assign drop      = rx_valid && (state != IDLE) && (state != HALF);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (rx_valid) state_n = HALF;
      HALF:     if (rx_valid) state_n = ISSUE;
      ISSUE:    state_n = WAIT_RES;
      WAIT_RES: begin
        if (res_hit)      state_n = SEND;
        else if (tmo_hit) state_n = IDLE;
      end
      SEND:     if (!tx_busy) state_n = TX_ACK;
      TX_ACK:   if (tx_busy) state_n = TX_WAIT;
      TX_WAIT:  if (!tx_busy) state_n = last_byte ? IDLE : SEND;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      sample_lo       <= '0;
      fir_input       <= '0;
      fir_input_valid <= 1'b0;
      tmo_cnt         <= '0;
      byte_idx        <= '0;
      result          <= '0;
      tx_data         <= '0;
      tx_start        <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_n;
      busy            <= (state_n != IDLE);
      fir_input_valid <= 1'b0;
      tx_start        <= 1'b0;

      if (state == IDLE && rx_valid) sample_lo <= rx_data;
      if (state == HALF && rx_valid) begin
        fir_input       <= {rx_data, sample_lo};
        fir_input_valid <= 1'b1;
      end

      if (state == ISSUE)    tmo_cnt <= '0;
      if (state == WAIT_RES) tmo_cnt <= tmo_cnt + 1'b1;

      if (res_hit) begin
        result   <= {{(RES_W - OUT_WIDTH){fir_output[OUT_WIDTH-1]}}, fir_output};
        byte_idx <= '0;
      end

      if (state == SEND && !tx_busy) begin
        tx_data  <= result[8*byte_idx +: 8];
        tx_start <= 1'b1;
      end
      if (state == TX_WAIT && !tx_busy && !last_byte) byte_idx <= byte_idx + 1'b1;

      // A fresh error event outranks a simultaneous clear.
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_uart_sequencer.sv
// Scoreboard bench: stimulus pushes expected samples/bytes, a negedge monitor pops and compares.
module tb_fir_uart_sequencer;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] fir_input;
  logic        fir_input_valid;
  logic [36:0] fir_output = '0;
  logic        fir_output_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  fir_uart_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .fir_input        (fir_input),
    .fir_input_valid  (fir_input_valid),
    .fir_output       (fir_output),
    .fir_output_valid (fir_output_valid),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_busy          (tx_busy),
    .busy             (busy),
    .overrun          (overrun),
    .timeout_err      (timeout_err),
    .err_clr          (err_clr)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          tx_cnt = 0;
  int          hold = 2;
  logic [15:0] sample_q[$];
  logic [7:0]  byte_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the result is a signed number; byte k of its 40-bit two's complement form.
  function automatic void push_result(input logic [36:0] r);
    longint v;
    v = longint'($signed(r));
    for (int k = 0; k < 5; k++) byte_q.push_back(8'((v >>> (8 * k)) & 64'hFF));
  endfunction

  // Monitor
  initial begin : mon
    logic [15:0] es;
    logic [7:0]  eb;
    forever begin
      @(negedge clk);
      if (fir_input_valid === 1'b1) begin
        chk("issue_expected", 64'(sample_q.size() > 0), 1);
        if (sample_q.size() > 0) begin
          es = sample_q.pop_front();
          chk("fir_input", fir_input, es);
        end
      end
      if (tx_start === 1'b1) begin
        tx_cnt++;
        chk("tx_start_while_busy", tx_busy, 0);
        chk("tx_expected", 64'(byte_q.size() > 0), 1);
        if (byte_q.size() > 0) begin
          eb = byte_q.pop_front();
          chk("tx_data", tx_data, eb);
        end
      end
    end
  end

  // UART TX model: goes busy a few cycles after tx_start, stays busy for 'hold' cycles.
  initial begin : uart
    int dly, left;
    dly = 0;
    left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        tx_busy = 1'b0; dly = 0; left = 0;
      end else if (tx_start) begin
        dly = $urandom_range(1, 3);
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin tx_busy = 1'b1; left = hold; end
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom());
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fir_input"}, fir_input, 0);
    chk({tag, "_fir_input_valid"}, fir_input_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic wait_done(input int base);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 5 * (hold + 12) + 20; c++) begin
      if (busy == 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("done_in_time", ok, 1);
    chk("bytes_sent", 64'(tx_cnt - base), 5);
    chk("bytes_left", 64'(byte_q.size()), 0);
  endtask

  // d: result arrives d cycles after the issue strobe cycle; d > TIMEOUT means it comes too late.
  task automatic run_txn(input logic [15:0] s, input logic [36:0] r, input int d, input bit ovr);
    int base;
    base = tx_cnt;
    send_byte(s[7:0]);
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    sample_q.push_back(s);
    send_byte(s[15:8]);
    chk("issue_strobe", fir_input_valid, 1);
    for (int k = 1; k <= d; k++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      err_clr = 1'b0;
      fir_output = 37'({$urandom(), $urandom()});
      if (k == 1) chk("issue_one_cycle", fir_input_valid, 0);
      if (ovr) begin
        case (k)
          4:  chk("overrun_pre", overrun, 0);
          5:  begin rx_data = 8'hAA; rx_valid = 1'b1; end
          7:  chk("overrun_set", overrun, 1);
          10: begin err_clr = 1'b1; rx_valid = 1'b1; end
          12: chk("overrun_clr_vs_drop", overrun, 1);
          13: err_clr = 1'b1;
          15: chk("overrun_cleared", overrun, 0);
          default: ;
        endcase
      end
      if (d > TIMEOUT && k == TIMEOUT) begin
        chk("timeout_not_yet", timeout_err, 0);
        chk("busy_waiting", busy, 1);
      end
      if (d > TIMEOUT && k == TIMEOUT + 1) begin
        chk("timeout_set", timeout_err, 1);
        chk("timeout_idle", busy, 0);
      end
    end
    fir_output = r;
    if (d <= TIMEOUT) push_result(r);
    fir_output_valid = 1'b1;
    @(posedge clk); #1;
    fir_output_valid = 1'b0;
    if (d <= TIMEOUT) begin
      wait_done(base);
      chk("no_timeout", timeout_err, 0);
      chk("no_overrun", overrun, 0);
    end else begin
      repeat (5) begin @(posedge clk); #1; end
      chk("late_result_ignored_busy", busy, 0);
      chk("late_result_no_tx", 64'(tx_cnt - base), 0);
      chk("timeout_sticky", timeout_err, 1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("timeout_cleared", timeout_err, 0);
    end
  endtask

  initial begin : stim
    int base;
    bit ok;
    logic [36:0] r;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    #2 rst = 1'b1;
    @(posedge clk); #1;

    run_txn(16'h1234, 37'd5, 195, 1'b0);
    run_txn(16'h8001, 37'h1F_FFFF_FFFE, 7, 1'b0);
    run_txn(16'($urandom()), 37'({$urandom(), $urandom()}), TIMEOUT, 1'b0);
    run_txn(16'($urandom()), 37'({$urandom(), $urandom()}), TIMEOUT + 1, 1'b0);
    run_txn(16'($urandom()), 37'({$urandom(), $urandom()}), 300, 1'b0);
    run_txn(16'h0BAD, 37'h0_1234_5678, 30, 1'b1);
    hold = 100;
    run_txn(16'($urandom()), 37'({$urandom(), $urandom()}), 10, 1'b0);

    // Reset in the middle of a transmit
    hold = 10;
    base = tx_cnt;
    send_byte(8'h78);
    sample_q.push_back(16'h5678);
    send_byte(8'h56);
    chk("mid_issue_strobe", fir_input_valid, 1);
    @(posedge clk); #1;
    r = 37'h0A_BCDE_F012;
    push_result(r);
    fir_output = r;
    fir_output_valid = 1'b1;
    @(posedge clk); #1;
    fir_output_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tx_cnt - base >= 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("two_bytes_before_reset", ok, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_reset");
    byte_q.delete();
    sample_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);
    hold = 2;
    run_txn(16'h0001, 37'd77, 4, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int d;
      hold = $urandom_range(1, 6);
      d = $urandom_range(1, 60);
      run_txn(16'($urandom()), 37'({$urandom(), $urandom()}), d, (d >= 20) && ($urandom_range(0, 1) == 1));
    end

    chk("final_issue_q_empty", 64'(sample_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end
endmodule
